pwm_deadtime: RTL and testbench

PWM_DEADTIME -- requirements
Module: pwm_deadtime

---
 rtl/pwm_pkg.sv | 15 +
 rtl/deadtime_leg.sv | 110 +++++++++++
 rtl/pwm_deadtime.sv | 50 +++++
 tb/tb_pwm_deadtime.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the dead-time PWM block: leg state encoding and
// default dead-time counter width.
package pwm_pkg;

  localparam int DT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    SAFE,
    LOW_ON,
    DEAD_H,
    HIGH_ON,
    DEAD_L
  } leg_state_t;

endpackage

// File: rtl/deadtime_leg.sv
// One half-bridge leg: input register, five-state gate FSM and dead-gap counter.
// Gate outputs are registered from the next-state decode so they move with the state.
module deadtime_leg
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            hold_safe,
  input  logic            pwm,
  input  logic [DT_W-1:0] dead_time,
  output logic            gate_hi,
  output logic            gate_lo
);

  logic            pwm_q;
  leg_state_t      state;
  leg_state_t      state_nxt;
  logic [DT_W-1:0] count;
  logic [DT_W-1:0] count_nxt;
  logic            hi_nxt;
  logic            lo_nxt;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    hi_nxt    = 1'b0;
    lo_nxt    = 1'b0;

    case (state)
      SAFE: begin
        state_nxt = LOW_ON;
        count_nxt = '0;
      end
      LOW_ON: begin
        if (pwm_q) begin
          if (dead_time == '0) begin
            state_nxt = HIGH_ON;
          end else begin
            state_nxt = DEAD_H;
            count_nxt = dead_time;
          end
        end
      end
      DEAD_H: begin
        // The count is the only timing source, so a late dead_time change cannot stretch the gap
        if (!pwm_q) begin
          state_nxt = LOW_ON;
          count_nxt = '0;
        end else if (count <= DT_W'(1)) begin
          state_nxt = HIGH_ON;
          count_nxt = '0;
        end else begin
          count_nxt = count - DT_W'(1);
        end
      end
      HIGH_ON: begin
        if (!pwm_q) begin
          if (dead_time == '0) begin
            state_nxt = LOW_ON;
          end else begin
            state_nxt = DEAD_L;
            count_nxt = dead_time;
          end
        end
      end
      DEAD_L: begin
        if (pwm_q) begin
          state_nxt = HIGH_ON;
          count_nxt = '0;
        end else if (count <= DT_W'(1)) begin
          state_nxt = LOW_ON;
          count_nxt = '0;
        end else begin
          count_nxt = count - DT_W'(1);
        end
      end
      default: begin
        state_nxt = SAFE;
        count_nxt = '0;
      end
    endcase

    if (hold_safe) begin
      state_nxt = SAFE;
      count_nxt = '0;
    end

    hi_nxt = (state_nxt == HIGH_ON);
    lo_nxt = (state_nxt == LOW_ON);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= SAFE;
      count   <= '0;
      pwm_q   <= 1'b0;
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      pwm_q   <= pwm;
      gate_hi <= hi_nxt;
      gate_lo <= lo_nxt;
    end
  end

endmodule

// File: rtl/pwm_deadtime.sv
// Multi-leg dead-time gate driver: fault latch and enable gating shared by
// all legs, one deadtime_leg per half-bridge.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int NUM_LEGS = 2,
  parameter int DT_W     = DT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [NUM_LEGS-1:0] pwm_in,
  input  logic [DT_W-1:0]     dead_time,
  input  logic                fault,
  input  logic                fault_clr,
  output logic [NUM_LEGS-1:0] gate_hi,
  output logic [NUM_LEGS-1:0] gate_lo,
  output logic                fault_latched
);

  logic hold_safe;

  // A fresh fault acts on the same edge it is latched, ahead of enable and pwm
  assign hold_safe = fault | fault_latched | ~enable;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fault_latched <= 1'b0;
    end else if (fault) begin
      fault_latched <= 1'b1;
    end else if (fault_clr) begin
      fault_latched <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_LEGS; i++) begin : g_leg
    deadtime_leg #(
      .DT_W(DT_W)
    ) u_leg (
      .clk       (clk),
      .resetn    (resetn),
      .hold_safe (hold_safe),
      .pwm       (pwm_in[i]),
      .dead_time (dead_time),
      .gate_hi   (gate_hi[i]),
      .gate_lo   (gate_lo[i])
    );
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime: cycle-by-cycle vector table, async
// reset sequences and a randomized overlap/dead-gap monitor.
module tb_pwm_deadtime;

  localparam int NUM_LEGS = 2;
  localparam int DT_W     = 8;

  logic                clk;
  logic                resetn;
  logic                enable;
  logic [NUM_LEGS-1:0] pwm_in;
  logic [DT_W-1:0]     dead_time;
  logic                fault;
  logic                fault_clr;
  logic [NUM_LEGS-1:0] gate_hi;
  logic [NUM_LEGS-1:0] gate_lo;
  logic                fault_latched;

  pwm_deadtime #(
    .NUM_LEGS(NUM_LEGS),
    .DT_W    (DT_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .pwm_in       (pwm_in),
    .dead_time    (dead_time),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .gate_hi      (gate_hi),
    .gate_lo      (gate_lo),
    .fault_latched(fault_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       enable;
    logic [1:0] pwm;
    logic [7:0] dt;
    logic       fault;
    logic       fault_clr;
    logic [1:0] exp_hi;
    logic [1:0] exp_lo;
    logic       exp_fl;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  // Random-phase monitor state
  bit         mon_on = 1'b0;
  int         edge_n;
  logic [1:0] prev_hi;
  logic [1:0] prev_lo;
  bit         pend_hi [NUM_LEGS];
  bit         pend_lo [NUM_LEGS];
  int         fall_edge_h [NUM_LEGS];
  int         fall_dt_h [NUM_LEGS];
  int         fall_edge_l [NUM_LEGS];
  int         fall_dt_l [NUM_LEGS];

  function automatic vec_t mk(input logic en, input logic [1:0] pwm, input logic [7:0] dt,
                              input logic f, input logic fc, input logic [1:0] ehi,
                              input logic [1:0] elo, input logic efl);
    vec_t v;
    v.enable    = en;
    v.pwm       = pwm;
    v.dt        = dt;
    v.fault     = f;
    v.fault_clr = fc;
    v.exp_hi    = ehi;
    v.exp_lo    = elo;
    v.exp_fl    = efl;
    return v;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic apply_stimulus(input vec_t v);
    enable    = v.enable;
    pwm_in    = v.pwm;
    dead_time = v.dt;
    fault     = v.fault;
    fault_clr = v.fault_clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watches every edge during the random phase: no overlap, and each hi/lo rise
  // after an FSM-driven fall of the other gate comes exactly dead_time edges later
  always @(posedge clk) begin
    if (mon_on) begin
      logic       en_s;
      int         dt_s;
      logic       hi, lo, phi, plo;
      en_s = enable;
      dt_s = int'(dead_time);
      #1;
      edge_n++;
      for (int i = 0; i < NUM_LEGS; i++) begin
        hi  = gate_hi[i];
        lo  = gate_lo[i];
        phi = prev_hi[i];
        plo = prev_lo[i];
        check_output($sformatf("overlap_leg%0d", i), int'(hi & lo), 0);
        if (!en_s) begin
          pend_hi[i] = 1'b0;
          pend_lo[i] = 1'b0;
        end else begin
          if (plo && !lo) begin
            pend_hi[i]     = 1'b1;
            fall_edge_h[i] = edge_n;
            fall_dt_h[i]   = dt_s;
            pend_lo[i]     = 1'b0;
          end
          if (phi && !hi) begin
            pend_lo[i]     = 1'b1;
            fall_edge_l[i] = edge_n;
            fall_dt_l[i]   = dt_s;
            pend_hi[i]     = 1'b0;
          end
          if (!phi && hi) begin
            if (pend_hi[i])
              check_output($sformatf("gap_lo2hi_leg%0d", i), edge_n - fall_edge_h[i], fall_dt_h[i]);
            pend_hi[i] = 1'b0;
            pend_lo[i] = 1'b0;
          end
          if (!plo && lo) begin
            if (pend_lo[i])
              check_output($sformatf("gap_hi2lo_leg%0d", i), edge_n - fall_edge_l[i], fall_dt_l[i]);
            pend_hi[i] = 1'b0;
            pend_lo[i] = 1'b0;
          end
        end
      end
      prev_hi = gate_hi;
      prev_lo = gate_lo;
    end
  end

  initial begin
    resetn    = 1'b0;
    enable    = 1'b1;
    pwm_in    = '0;
    dead_time = 8'd5;
    fault     = 1'b0;
    fault_clr = 1'b0;

    // Leg-0 rise/fall with dead_time=5, including a dead_time change mid-gap
    vecs.push_back(mk(1, 2'b00, 5, 0, 0, 2'b00, 2'b11, 0));
    vecs.push_back(mk(1, 2'b01, 5, 0, 0, 2'b00, 2'b11, 0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(1, 2'b01, 5, 0, 0, 2'b00, 2'b10, 0));
    vecs.push_back(mk(1, 2'b01, 5, 0, 0, 2'b01, 2'b10, 0));
    vecs.push_back(mk(1, 2'b01, 5, 0, 0, 2'b01, 2'b10, 0));
    vecs.push_back(mk(1, 2'b00, 5, 0, 0, 2'b01, 2'b10, 0));
    vecs.push_back(mk(1, 2'b00, 5, 0, 0, 2'b00, 2'b10, 0));
    vecs.push_back(mk(1, 2'b00, 5, 0, 0, 2'b00, 2'b10, 0));
    vecs.push_back(mk(1, 2'b00, 2, 0, 0, 2'b00, 2'b10, 0));
    vecs.push_back(mk(1, 2'b00, 2, 0, 0, 2'b00, 2'b10, 0));
    vecs.push_back(mk(1, 2'b00, 2, 0, 0, 2'b00, 2'b10, 0));
    vecs.push_back(mk(1, 2'b00, 2, 0, 0, 2'b00, 2'b11, 0));
    // dead_time=0: hi and lo swap on one edge
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 2'b00, 2'b11, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b01, 2'b10, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 2'b00, 2'b11, 0));
    vecs.push_back(mk(1, 2'b01, 0, 0, 0, 2'b01, 2'b10, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b01, 2'b10, 0));
    vecs.push_back(mk(1, 2'b00, 0, 0, 0, 2'b00, 2'b11, 0));
    // dead_time=10, short pulse on leg 1 aborts the gap
    vecs.push_back(mk(1, 2'b10, 10, 0, 0, 2'b00, 2'b11, 0));
    vecs.push_back(mk(1, 2'b10, 10, 0, 0, 2'b00, 2'b01, 0));
    vecs.push_back(mk(1, 2'b10, 10, 0, 0, 2'b00, 2'b01, 0));
    vecs.push_back(mk(1, 2'b00, 10, 0, 0, 2'b00, 2'b01, 0));
    vecs.push_back(mk(1, 2'b00, 10, 0, 0, 2'b00, 2'b11, 0));
    vecs.push_back(mk(1, 2'b00, 10, 0, 0, 2'b00, 2'b11, 0));
    // Fault while HIGH_ON, clear ignored alongside fault, then real clear
    vecs.push_back(mk(1, 2'b11, 1, 0, 0, 2'b00, 2'b11, 0));
    vecs.push_back(mk(1, 2'b11, 1, 0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 2'b11, 1, 0, 0, 2'b11, 2'b00, 0));
    vecs.push_back(mk(1, 2'b11, 1, 1, 0, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2'b11, 1, 0, 0, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2'b11, 1, 1, 1, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2'b11, 1, 0, 1, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 2'b11, 1, 0, 0, 2'b00, 2'b11, 0));
    vecs.push_back(mk(1, 2'b11, 1, 0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 2'b11, 1, 0, 0, 2'b11, 2'b00, 0));
    // enable drop, then fault overriding enable=1
    vecs.push_back(mk(0, 2'b11, 1, 0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, 2'b11, 1, 0, 0, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 2'b00, 1, 0, 0, 2'b00, 2'b11, 0));
    vecs.push_back(mk(1, 2'b00, 1, 0, 0, 2'b00, 2'b11, 0));
    vecs.push_back(mk(1, 2'b00, 1, 1, 0, 2'b00, 2'b00, 1));
    vecs.push_back(mk(1, 2'b00, 1, 0, 1, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, 2'b00, 1, 0, 0, 2'b00, 2'b11, 0));

    tick();
    tick();
    check_output("reset_hi", int'(gate_hi), 0);
    check_output("reset_lo", int'(gate_lo), 0);
    check_output("reset_fl", int'(fault_latched), 0);
    resetn = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      apply_stimulus(vecs[k]);
      tick();
      check_output($sformatf("vec%0d_hi", k), int'(gate_hi), int'(vecs[k].exp_hi));
      check_output($sformatf("vec%0d_lo", k), int'(gate_lo), int'(vecs[k].exp_lo));
      check_output($sformatf("vec%0d_fl", k), int'(fault_latched), int'(vecs[k].exp_fl));
    end

    // Async reset in the middle of a dead gap, then a clean restart
    pwm_in    = 2'b01;
    dead_time = 8'd10;
    tick();
    tick();
    check_output("seqA_dead_lo", int'(gate_lo), 2);
    check_output("seqA_dead_hi", int'(gate_hi), 0);
    #3;
    resetn = 1'b0;
    #1;
    check_output("seqA_async_hi", int'(gate_hi), 0);
    check_output("seqA_async_lo", int'(gate_lo), 0);
    pwm_in = 2'b00;
    tick();
    resetn = 1'b1;
    tick();
    check_output("seqA_first_edge_lo", int'(gate_lo), 3);
    check_output("seqA_first_edge_hi", int'(gate_hi), 0);
    pwm_in    = 2'b01;
    dead_time = 8'd3;
    tick();
    check_output("seqA_e1_lo", int'(gate_lo), 3);
    tick();
    check_output("seqA_e2_lo", int'(gate_lo), 2);
    tick();
    tick();
    check_output("seqA_e4_hi", int'(gate_hi), 0);
    tick();
    check_output("seqA_e5_hi", int'(gate_hi), 1);
    check_output("seqA_e5_lo", int'(gate_lo), 2);

    // Async reset clears a latched fault
    fault = 1'b1;
    tick();
    fault = 1'b0;
    check_output("seqB_fault_set", int'(fault_latched), 1);
    #3;
    resetn = 1'b0;
    #1;
    check_output("seqB_async_fl", int'(fault_latched), 0);
    check_output("seqB_async_hi", int'(gate_hi), 0);
    tick();
    resetn = 1'b1;
    tick();
    check_output("seqB_restart_lo", int'(gate_lo), 3);
    pwm_in = 2'b00;
    tick();

    // Randomized phase watched by the monitor
    prev_hi = gate_hi;
    prev_lo = gate_lo;
    edge_n  = 0;
    for (int i = 0; i < NUM_LEGS; i++) begin
      pend_hi[i] = 1'b0;
      pend_lo[i] = 1'b0;
    end
    mon_on = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      for (int b = 0; b < NUM_LEGS; b++)
        if ($urandom_range(7) == 0) pwm_in[b] = ~pwm_in[b];
      if ($urandom_range(15) == 0) dead_time = 8'($urandom_range(7));
      enable = ($urandom_range(63) != 0);
      tick();
    end
    mon_on = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
